// File: rtl/vco_adc_pkg.sv
// Shared sizing for the VCO-ADC decimation path.
package vco_adc_pkg;

    localparam int PHASE_WIDTH_DEF = 11;
    localparam int OSR_LOG2_DEF    = 9;
    localparam int WARMUP_FRAMES   = 2;

    function automatic int out_width(input int phase_w, input int osr_log2);
        return phase_w + 2 * osr_log2;
    endfunction

endpackage

// File: rtl/cic2_decim.sv
// Second-order CIC decimator: two integrators, frame counter, two combs.
module cic2_decim
    import vco_adc_pkg::*;
#(
    parameter int IN_WIDTH  = PHASE_WIDTH_DEF,
    parameter int OSR_LOG2  = OSR_LOG2_DEF,
    parameter int OUT_WIDTH = out_width(IN_WIDTH, OSR_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [IN_WIDTH-1:0]  d_i,
    output logic                 strobe_o,
    output logic [OUT_WIDTH-1:0] comb_o
);

    logic [OSR_LOG2-1:0]  cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] i1_q, i1_d;
    logic [OUT_WIDTH-1:0] i2_q, i2_d;
    logic [OUT_WIDTH-1:0] i2_last_q, i2_last_d;
    logic [OUT_WIDTH-1:0] c1_last_q, c1_last_d;
    logic [OUT_WIDTH-1:0] c1, c2;

    assign strobe_o = enable_i && (cnt_q == {OSR_LOG2{1'b1}});
    assign c1       = i2_q - i2_last_q;
    assign c2       = c1 - c1_last_q;
    assign comb_o   = c2;

    always_comb begin
        cnt_d     = cnt_q;
        i1_d      = i1_q;
        i2_d      = i2_q;
        i2_last_d = i2_last_q;
        c1_last_d = c1_last_q;
        if (!enable_i) begin
            cnt_d     = '0;
            i1_d      = '0;
            i2_d      = '0;
            i2_last_d = '0;
            c1_last_d = '0;
        end else begin
            // OSR is a power of two, so the counter wraps by overflow
            cnt_d = cnt_q + 1'b1;
            i1_d  = i1_q + OUT_WIDTH'(d_i);
            i2_d  = i2_q + i1_q;
            if (strobe_o) begin
                i2_last_d = i2_q;
                c1_last_d = c1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i2_last_q <= '0;
            c1_last_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i2_last_q <= i2_last_d;
            c1_last_q <= c1_last_d;
        end
    end

endmodule

// File: rtl/vco_decimator.sv
// VCO phase differencer, CIC2 decimation, warm-up gating and output handshake.
module vco_decimator
    import vco_adc_pkg::*;
#(
    parameter  int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter  int OSR_LOG2    = OSR_LOG2_DEF,
    localparam int OUT_WIDTH   = out_width(PHASE_WIDTH, OSR_LOG2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [PHASE_WIDTH-1:0] phase_i,
    output logic [OUT_WIDTH-1:0]   data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o
);

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] phase_prev_q, phase_prev_d;
    logic [PHASE_WIDTH-1:0] diff;
    logic                   first_q, first_d;
    logic [1:0]             warm_q, warm_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic                   strobe;
    logic [OUT_WIDTH-1:0]   comb;
    logic                   accept;
    logic                   emit;

    assign diff   = first_q ? '0 : phase_q - phase_prev_q;
    assign accept = valid_q && ready_i;
    assign emit   = strobe && (warm_q == 2'(WARMUP_FRAMES));

    cic2_decim #(
        .IN_WIDTH  (PHASE_WIDTH),
        .OSR_LOG2  (OSR_LOG2),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_cic (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable_i),
        .d_i      (diff),
        .strobe_o (strobe),
        .comb_o   (comb)
    );

    always_comb begin
        phase_d      = phase_q;
        phase_prev_d = phase_prev_q;
        first_d      = first_q;
        warm_d       = warm_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ovr_d        = ovr_q;
        if (!enable_i) begin
            first_d = 1'b1;
            warm_d  = '0;
            valid_d = 1'b0;
        end else begin
            phase_d = phase_i;
            // Seed prev with the fresh sample so stale phase never yields a step
            phase_prev_d = first_q ? phase_i : phase_q;
            first_d      = 1'b0;
            if (strobe && !emit) begin
                warm_d = warm_q + 2'd1;
            end
            if (accept) begin
                valid_d = 1'b0;
            end
            if (emit) begin
                if (valid_q && !ready_i) begin
                    ovr_d = 1'b1;
                end else begin
                    data_d  = comb;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q      <= '0;
            phase_prev_q <= '0;
            first_q      <= 1'b1;
            warm_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            phase_prev_q <= phase_prev_d;
            first_q      <= first_d;
            warm_q       <= warm_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule
